mem_lsu_ctrl: RTL

//  Load/store unit for the MEM stage. Consumes the MEM-stage strobes (mem_wren,

---
 rtl/mem_lsu_ctrl_if.sv | 21 ++
 rtl/mem_lsu_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage load/store unit
// (master) and the data memory (slave).
interface mem_lsu_ctrl_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [29:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store unit: checks access legality, runs one req/ack bus cycle
// with byte enables, stalls the pipeline meanwhile and returns extended load data.
module mem_lsu_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_mem_wren,
    input  logic         i_mem_rden,
    input  logic [2:0]   i_funct3,
    input  logic [31:0]  i_addr,
    input  logic [31:0]  i_st_data,
    output logic         o_stall,
    output logic [31:0]  o_ld_data,
    output logic         o_ld_valid,
    output logic         o_misalign,
    output logic         o_bus_err,
    mem_lsu_ctrl_if.master dmem
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        RESP     = 2'd2,
        RESP_ERR = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          we_q;
    logic [29:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic [31:0]   ld_data_q;
    logic          ld_valid_q;
    logic          bus_err_q;

    logic          access;
    logic          illegal;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   shifted;
    logic [31:0]   ld_ext_d;

    always_comb begin
        access  = i_mem_wren | i_mem_rden;
        illegal = 1'b0;
        if (i_mem_wren && i_mem_rden) begin
            illegal = 1'b1;
        end else if (i_mem_wren) begin
            illegal = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010);
        end else begin
            illegal = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010 ||
                        i_funct3 == 3'b100 || i_funct3 == 3'b101);
        end
        // funct3[1:0] encodes size for both signed and unsigned loads
        case (i_funct3[1:0])
            2'b01:   if (i_addr[0]) illegal = 1'b1;
            2'b10:   if (i_addr[1:0] != 2'b00) illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_d = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Word accesses are aligned, so lane_q is 0 and the shift is a pass-through.
    always_comb begin
        shifted  = dmem.i_dmem_rdata >> {lane_q, 3'b000};
        ld_ext_d = shifted;
        case (f3_q[1:0])
            2'b00:   ld_ext_d = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_ext_d = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (access && !illegal) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= i_mem_wren;
                        addr_q  <= i_addr[31:2];
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        f3_q    <= i_funct3;
                        lane_q  <= i_addr[1:0];
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (dmem.i_dmem_ack) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        if (!we_q) begin
                            ld_data_q  <= ld_ext_d;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RESP_ERR;
                        req_q     <= 1'b0;
                        cnt_q     <= '0;
                        ld_data_q <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP, RESP_ERR: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_stall    = i_rst_n && (((state_q == IDLE) && access && !illegal) || (state_q == BUSY));
    assign o_misalign = i_rst_n && (state_q == IDLE) && access && illegal;
    assign o_ld_data  = ld_data_q;
    assign o_ld_valid = ld_valid_q;
    assign o_bus_err  = bus_err_q;

    assign dmem.o_dmem_req   = req_q;
    assign dmem.o_dmem_we    = we_q;
    assign dmem.o_dmem_addr  = addr_q;
    assign dmem.o_dmem_be    = be_q;
    assign dmem.o_dmem_wdata = wdata_q;
endmodule
